// File: rtl/program_mem_loader_if.sv
// Load and fetch port bundle for program_mem_loader: byte-serial valid/ready
// load channel plus the zero-latency instruction fetch path.
interface program_mem_loader_if #(
  parameter int unsigned Bits     = 8,
  parameter int unsigned AddrBits = 4
);
  logic                load_valid;
  logic [Bits-1:0]     load_data;
  logic                load_ready;
  logic [AddrBits-1:0] ProgramAddress;
  logic [Bits-1:0]     instruction_data;

  modport master (
    output load_valid, load_data, ProgramAddress,
    input  load_ready, instruction_data
  );

  modport slave (
    input  load_valid, load_data, ProgramAddress,
    output load_ready, instruction_data
  );
endinterface

// File: rtl/program_mem_loader.sv
// Instruction memory for the K2 core: loads a program byte-serially while holding
// the core in reset, then serves fetches. Optional macro: LOADER_CHECKSUM_EN.
module program_mem_loader #(
  parameter int unsigned Bits     = 8,
  parameter int unsigned AddrBits = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  program_mem_loader_if.slave lif,
  input  logic                start,
  input  logic                reload,
  output logic                core_rst_n,
  output logic [AddrBits-1:0] wr_ptr,
  output logic                loading,
  output logic [Bits-1:0]     checksum
);

  localparam int unsigned DEPTH = 2 ** AddrBits;
  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic [AddrBits-1:0] wr_ptr_nxt;
  logic                accept;
  logic                last_word;
  logic [Bits-1:0]     mem [DEPTH];

  // Status and handshake are decoded straight from the state.
  assign lif.load_ready       = (state == LOAD);
  assign loading              = (state == LOAD);
  assign accept               = (state == LOAD) && lif.load_valid;
  assign last_word            = (wr_ptr == AddrBits'(DEPTH - 1));
  assign lif.instruction_data = mem[lif.ProgramAddress];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      core_rst_n <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      core_rst_n <= (state_nxt == RUN);
    end
  end

  // Next-state logic; a start coinciding with a valid still writes that word.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    case (state)
      LOAD: begin
        if (accept) begin
          wr_ptr_nxt = wr_ptr + AddrBits'(1);
        end
        if (start || (accept && last_word)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (reload) begin
          state_nxt  = LOAD;
          wr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt  = LOAD;
        wr_ptr_nxt = '0;
      end
    endcase
  end

  // Storage is cleared only by reset; a reload overwrites from address 0 upward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (accept) begin
      mem[wr_ptr] <= lif.load_data;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [Bits-1:0] sum_q;

  // Modulo-2**Bits sum of accepted words, restarted on each reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + lif.load_data;
    end else if ((state == RUN) && reload) begin
      sum_q <= '0;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_mem_loader.sv
// Directed bench for program_mem_loader: reset, full/partial loads, early start,
// reload and the optional checksum.
module tb_program_mem_loader;

  localparam int unsigned Bits     = 8;
  localparam int unsigned AddrBits = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                reload;
  logic                core_rst_n;
  logic [AddrBits-1:0] wr_ptr;
  logic                loading;
  logic [Bits-1:0]     checksum;

  int pass_cnt = 0;
  int total    = 0;

  program_mem_loader_if #(.Bits(Bits), .AddrBits(AddrBits)) lif ();

  program_mem_loader #(.Bits(Bits), .AddrBits(AddrBits)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lif        (lif.slave),
    .start      (start),
    .reload     (reload),
    .core_rst_n (core_rst_n),
    .wr_ptr     (wr_ptr),
    .loading    (loading),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_mem(input string tag, input int addr, input logic [7:0] exp);
    lif.ProgramAddress = AddrBits'(addr);
    #1;
    check(tag, 32'(lif.instruction_data), 32'(exp));
  endtask

  task automatic push(input logic [7:0] d);
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    step();
    lif.load_valid = 1'b0;
  endtask

  function automatic logic [7:0] exp_sum(input logic [7:0] s);
`ifdef LOADER_CHECKSUM_EN
    return s;
`else
    return (s == s) ? 8'h00 : 8'hFF;
`endif
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; reload = 1'b0;
    lif.load_valid = 1'b0; lif.load_data = '0; lif.ProgramAddress = '0;
    step(); step();
    check("rst_loading", 32'(loading), 32'd1);
    check("rst_load_ready", 32'(lif.load_ready), 32'd1);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) check_mem("rst_mem", a, 8'h00);

    // Full load of 0x10..0x1F, valid every cycle.
    for (int i = 0; i < 16; i++) begin
      check("full_wr_ptr", 32'(wr_ptr), 32'(i));
      check("full_still_loading", 32'(loading), 32'd1);
      lif.load_valid = 1'b1;
      lif.load_data  = 8'(8'h10 + i);
      step();
    end
    lif.load_valid = 1'b0;
    check("full_run_loading", 32'(loading), 32'd0);
    check("full_run_ready", 32'(lif.load_ready), 32'd0);
    check("full_run_core_rst_n", 32'(core_rst_n), 32'd1);
    check("full_wrap_ptr", 32'(wr_ptr), 32'd0);
    check("full_checksum", 32'(checksum), 32'(exp_sum(8'h78)));
    check_mem("full_addr5", 5, 8'h15);
    check_mem("full_addr15", 15, 8'h1F);

    // RUN ignores load_valid and start.
    lif.load_valid = 1'b1; lif.load_data = 8'hEE; start = 1'b1;
    step();
    lif.load_valid = 1'b0; start = 1'b0;
    check_mem("run_ignore_valid", 0, 8'h10);
    check("run_ignore_ptr", 32'(wr_ptr), 32'd0);
    check("run_hold_checksum", 32'(checksum), 32'(exp_sum(8'h78)));

    // Reload, then load with gaps in valid.
    reload = 1'b1; step(); reload = 1'b0;
    check("reload_loading", 32'(loading), 32'd1);
    check("reload_core_rst_n", 32'(core_rst_n), 32'd0);
    check("reload_checksum", 32'(checksum), 32'd0);
    push(8'hA1);
    step(); step();
    push(8'hA2);
    check_mem("gap_mem0", 0, 8'hA1);
    check_mem("gap_mem1", 1, 8'hA2);
    check_mem("gap_mem2_kept", 2, 8'h12);
    check("gap_wr_ptr", 32'(wr_ptr), 32'd2);
    check("gap_loading", 32'(loading), 32'd1);
    check("gap_checksum", 32'(checksum), 32'(exp_sum(8'h43)));

    // Partial reload overwrites only address 0.
    start = 1'b1; step(); start = 1'b0;
    check("start_core_rst_n", 32'(core_rst_n), 32'd1);
    reload = 1'b1; step(); reload = 1'b0;
    check("reload2_core_rst_n", 32'(core_rst_n), 32'd0);
    push(8'h99);
    step();
    check_mem("partial_mem0", 0, 8'h99);
    check_mem("partial_mem1", 1, 8'hA2);
    check("partial_core_rst_n", 32'(core_rst_n), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    check("partial_start_core", 32'(core_rst_n), 32'd1);

    // Early start with a simultaneous valid word.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    push(8'h33);
    lif.load_valid = 1'b1; lif.load_data = 8'h44; start = 1'b1;
    step();
    lif.load_valid = 1'b0; start = 1'b0;
    check("early_loading", 32'(loading), 32'd0);
    check("early_core_rst_n", 32'(core_rst_n), 32'd1);
    check("early_wr_ptr", 32'(wr_ptr), 32'd2);
    check_mem("early_mem0", 0, 8'h33);
    check_mem("early_mem1", 1, 8'h44);
    for (int a = 2; a < 16; a++) check_mem("early_tail_zero", a, 8'h00);
    check("early_checksum", 32'(checksum), 32'(exp_sum(8'h77)));

    // Reset mid-load at wr_ptr 7, with a valid word present.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 7; i++) push(8'(8'h50 + i));
    check("midload_wr_ptr", 32'(wr_ptr), 32'd7);
    check_mem("midload_mem6", 6, 8'h56);
    lif.load_valid = 1'b1; lif.load_data = 8'h77; rst_n = 1'b0;
    step();
    lif.load_valid = 1'b0; rst_n = 1'b1;
    check("midrst_wr_ptr", 32'(wr_ptr), 32'd0);
    check("midrst_loading", 32'(loading), 32'd1);
    for (int a = 0; a < 16; a++) check_mem("midrst_mem_zero", a, 8'h00);

    // Checksum wraps modulo 256; reload is ignored while loading.
    push(8'hF0); push(8'h20); push(8'h05);
    check("cks_sum", 32'(checksum), 32'(exp_sum(8'h15)));
    reload = 1'b1; step(); reload = 1'b0;
    check("load_reload_ignored_ptr", 32'(wr_ptr), 32'd3);
    check("load_reload_ignored_cks", 32'(checksum), 32'(exp_sum(8'h15)));
    start = 1'b1; step(); start = 1'b0;
    reload = 1'b1; step(); reload = 1'b0;
    check("cks_after_reload", 32'(checksum), 32'd0);
    check_mem("cks_mem2", 2, 8'h05);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/program_mem_loader.md
Name: program_mem_loader

Overview:
- Instruction-memory responder for the K2 core's fetch interface.
- The core drives `ProgramAddress` and this block returns `instruction_data`.
- Before execution the block accepts a program through a byte-serial valid/ready load port and holds the core in reset (`core_rst_n` low).
- Once the program is loaded it switches to run mode and serves fetches from the loaded image.

Parameters:
- `Bits`, 8, instruction word width.
- `AddrBits`, 4, program address width; depth `DEPTH` = 2**`AddrBits` (16).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous active-low reset.
- `load_valid`  input  1  a load byte is present on `load_data`.
- `load_data`  input  `Bits`  program word to store at the current write pointer.
- `load_ready`  output  1  block accepts a load word this cycle.
- `start`  input  1  end loading early and enter run mode.
- `reload`  input  1  leave run mode and restart loading from address 0.
- `ProgramAddress`  input  `AddrBits`  fetch address from the core.
- `instruction_data`  output  `Bits`  fetched instruction.
- `core_rst_n`  output  1  active-low reset to the core; low while loading.
- `wr_ptr`  output  `AddrBits`  next load address (status).
- `loading`  output  1  high in state LOAD.
- `checksum`  output  `Bits`  running sum of loaded words (see Optional Feature).

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst_n` is synchronous and active-low.
- State register: two states, LOAD and RUN.
- Reset (`rst_n`=0 sampled at a clock edge):
  - state <= LOAD; `wr_ptr` <= 0; all `DEPTH` memory words <= 0.
  - `core_rst_n` <= 0; `checksum` <= 0.
  - Reset has priority over every other input, including mid-load and mid-run.
- LOAD:
  - `load_ready` = 1 and `loading` = 1 (combinational from state); `core_rst_n` held 0.
  - Accept: when `load_valid` && `load_ready`, mem[`wr_ptr`] <= `load_data` and `wr_ptr` <= `wr_ptr`+1 (wraps modulo `DEPTH`).
  - Full: an accept with `wr_ptr` == `DEPTH`-1 writes the last word, wraps `wr_ptr` to 0, and transitions to RUN.
  - Early end: `start`=1 transitions to RUN. If `load_valid` is also high that cycle, the word is written first. Unwritten words keep their prior contents (0 after reset).
  - `reload` is ignored in LOAD.
- RUN:
  - `load_ready` = 0; `load_valid` ignored; `start` ignored.
  - `core_rst_n` = 1, registered: it rises on the same edge that enters RUN, so the core sees its first non-reset cycle one cycle after the final accept or `start`.
  - `reload`=1 → next edge: state <= LOAD, `wr_ptr` <= 0, `core_rst_n` <= 0. Memory is NOT cleared, so a partial reload overwrites only the low addresses.
- Fetch:
  - `instruction_data` = mem[`ProgramAddress`], combinational, in both states. In LOAD the value is don't-care to the core but must still be the stored word.
  - Zero-latency read: the core samples it in the same cycle it drives the address.
  - Write then read of the same address: the new value is visible the cycle after the write edge.
- Storage: `DEPTH` x `Bits` flip-flop array with a single write port and a combinational read; no ready/valid on the fetch side.

Optional Feature:
- Macro: `LOADER_CHECKSUM_EN`.
- Defined:
  - `checksum` accumulates sum of accepted `load_data` modulo 2**`Bits`.
  - Cleared on reset and on the `reload` transition into LOAD; held in RUN.
- Undefined: `checksum` tied to 0 and no accumulator is synthesised.

Test Plan:
- Reset then idle: `rst_n`=0 for 2 cycles → `loading`=1, `load_ready`=1, `core_rst_n`=0, `wr_ptr`=0; `instruction_data`=0x00 for all 16 addresses.
- Full load: stream words 0x10..0x1F, valid every cycle.
  - `wr_ptr` counts 0..15 and wraps to 0.
  - RUN entered on the 16th accept edge; `core_rst_n`=1 and `load_ready`=0 from that edge.
  - `ProgramAddress`=5 → 0x15; `ProgramAddress`=15 → 0x1F.
- Backpressure gaps: `load_valid` toggles 1,0,0,1 with data 0xA1,-,-,0xA2 → mem[0]=0xA1, mem[1]=0xA2, `wr_ptr`=2, still LOAD.
- Early start with simultaneous valid: load 0x33 at addr 0, then `start`=1 with `load_valid`=1 and data 0x44 → mem[1]=0x44, RUN next edge, addr 2..15 read 0x00.
- Reload and reset:
  - In RUN assert `reload`, load 0x99 → mem[0]=0x99, mem[1] retains its previous value, `core_rst_n`=0 until `start`.
  - `rst_n`=0 mid-load at `wr_ptr`=7 → all words 0, `wr_ptr`=0.
- Checksum (`LOADER_CHECKSUM_EN` defined): load 0xF0, 0x20, 0x05 → `checksum`=0x15; after `reload` → 0x00. With the macro undefined, `checksum` stays 0x00.
